int_ctrl: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 21 ++
 rtl/int_ctrl_arb.sv | 42 ++++
 rtl/int_ctrl.sv | 160 ++++++++++++++++
 tb/tb_int_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared constants and types for the interrupt controller
// Optional feature macro: INT_CTRL_PRIO_EN (per-source priority register)
package int_ctrl_pkg;

  // Register offsets within the 32-byte window (addr_i[4:0])
  localparam logic [4:0] OFF_ENABLE  = 5'h00;
  localparam logic [4:0] OFF_PENDING = 5'h04;
  localparam logic [4:0] OFF_CLAIM   = 5'h08;
  localparam logic [4:0] OFF_PRIO    = 5'h0C;

  // Priority field width per source
  localparam int PRIO_W = 2;

  // Controller states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_ctrl_arb.sv
// rtl/int_ctrl_arb.sv - combinational winner select over eligible sources
// Optional feature macro: INT_CTRL_PRIO_EN (priority-based selection)
module int_ctrl_arb
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0]        eligible,
`ifdef INT_CTRL_PRIO_EN
  input  logic [PRIO_W*NUM_SRC-1:0] prio,
`endif
  output logic [ID_W-1:0]           win_id
);

`ifdef INT_CTRL_PRIO_EN
  logic [PRIO_W-1:0] best;

  // Highest priority wins; strict '>' keeps the lowest index on ties
  always_comb begin
    win_id = '0;
    best   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && ((win_id == '0) || (prio[PRIO_W*i +: PRIO_W] > best))) begin
        win_id = ID_W'(i + 1);
        best   = prio[PRIO_W*i +: PRIO_W];
      end
    end
  end
`else
  // Fixed priority: scan from the top so the lowest eligible index is last written
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_W'(i + 1);
      end
    end
  end
`endif

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-capturing interrupt controller with claim/complete window
// Optional feature macro: INT_CTRL_PRIO_EN (PRIO register at 0x0C)
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic [3:0]         sel_i,
  input  logic               we_i,
  input  logic               req_valid_i,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o
);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    claimed_id;
  state_e             state;
  state_e             state_next;
  logic [31:0]        wmask;
  logic [31:0]        rdata;
  logic [4:0]         off;
  logic               rd;
  logic               wr;
  logic               claim_rd;
  logic               claim_take;
  logic               complete;
  logic               unused_bits;

`ifdef INT_CTRL_PRIO_EN
  logic [PRIO_W*NUM_SRC-1:0] prio;
`endif

  assign off      = addr_i[4:0];
  assign rd       = req_valid_i & ~we_i;
  assign wr       = req_valid_i & we_i;
  assign rise     = irq_src_i & ~src_q;
  assign eligible = pending & enable;

  // A claim only has an effect while a source is being offered
  assign claim_rd   = rd && (off == OFF_CLAIM) && (state == OFFER);
  assign claim_take = claim_rd && (win_id != '0);
  assign complete   = wr && (off == OFF_CLAIM) && (state == SERVICE) &&
                      (data_i[ID_W-1:0] == claimed_id);

  assign unused_bits = ^{addr_i[31:5], data_i, wmask};

  int_ctrl_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .eligible (eligible),
`ifdef INT_CTRL_PRIO_EN
    .prio     (prio),
`endif
    .win_id   (win_id)
  );

  // Expand byte enables into a per-bit write mask
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 32; b++) begin
      wmask[b] = sel_i[b/8];
    end
  end

  // One-hot clear of the claimed source's pending bit
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = claim_take && (win_id == ID_W'(i + 1));
    end
  end

  // Read data mux; CLAIM returns the offered id only while offering
  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_ENABLE:  rdata[NUM_SRC-1:0] = enable;
      OFF_PENDING: rdata[NUM_SRC-1:0] = pending;
      OFF_CLAIM:   if (state == OFFER) rdata[ID_W-1:0] = win_id;
`ifdef INT_CTRL_PRIO_EN
      OFF_PRIO:    rdata[PRIO_W*NUM_SRC-1:0] = prio;
`endif
      default:     rdata = '0;
    endcase
  end

  // Next-state logic for the offer/claim/complete handshake
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (eligible != '0) state_next = OFFER;
      OFFER: begin
        if (claim_take)           state_next = SERVICE;
        else if (eligible == '0)  state_next = IDLE;
      end
      SERVICE: if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequential state: edge capture, pending, registers, FSM, read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      pending    <= '0;
      enable     <= '0;
      state      <= IDLE;
      claimed_id <= '0;
      data_o     <= '0;
    end else begin
      src_q   <= irq_src_i;
      // New edges win over a same-cycle claim clear
      pending <= (pending & ~clr) | rise;
      if (wr && (off == OFF_ENABLE)) begin
        enable <= (enable & ~wmask[NUM_SRC-1:0]) | (data_i[NUM_SRC-1:0] & wmask[NUM_SRC-1:0]);
      end
      if (claim_take) begin
        claimed_id <= win_id;
      end
      state  <= state_next;
      data_o <= rd ? rdata : 32'h0;
    end
  end

`ifdef INT_CTRL_PRIO_EN
  // Priority register, byte-lane writable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= '0;
    end else if (wr && (off == OFF_PRIO)) begin
      prio <= (prio & ~wmask[PRIO_W*NUM_SRC-1:0]) |
              (data_i[PRIO_W*NUM_SRC-1:0] & wmask[PRIO_W*NUM_SRC-1:0]);
    end
  end
`endif

  // Outputs decode straight from registered state
  assign irq_o = (state == OFFER);

  always_comb begin
    irq_id_o = '0;
    if (state == OFFER)        irq_id_o = win_id;
    else if (state == SERVICE) irq_id_o = claimed_id;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed scoreboard bench for int_ctrl
module tb_int_ctrl;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        addr;
  logic [31:0]        wdata;
  logic [3:0]         sel;
  logic               we;
  logic               req;
  logic [31:0]        rdata;
  logic [NUM_SRC-1:0] src;
  logic               irq;
  logic [ID_W-1:0]    irq_id;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  int_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (addr),
    .data_i      (wdata),
    .sel_i       (sel),
    .we_i        (we),
    .req_valid_i (req),
    .data_o      (rdata),
    .irq_src_i   (src),
    .irq_o       (irq),
    .irq_id_o    (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp_irq, input logic [31:0] exp_id);
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, exp_irq});
    check({tag, "_id"}, {{(32-ID_W){1'b0}}, irq_id}, exp_id);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    addr = {27'h0, a}; we = 1'b0; sel = 4'hF; req = 1'b1;
    tick();
    req = 1'b0;
    if (exp_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = {27'h0, a}; wdata = d; we = 1'b1; sel = s; req = 1'b1;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] first_id;
    logic [31:0] second_id;
    rst_n = 1'b0; addr = '0; wdata = '0; sel = '0; we = 1'b0; req = 1'b0; src = '0;
    repeat (3) tick();
    check("rst_data", rdata, 32'h0);
    check_irq("rst", 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    bus_read(5'h00, 32'h0, "rst_enable");
    bus_read(5'h04, 32'h0, "rst_pending");

    // Single pulse on source 0: pending after one edge, irq after two
    bus_write(5'h00, 32'h1, 4'hF);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    check_irq("pulse_n1", 1'b0, 32'h0);
    bus_read(5'h04, 32'h1, "pulse_pending");
    check_irq("pulse_n2", 1'b1, 32'h1);

    // Claim, repeated claim, wrong and right completion
    bus_read(5'h08, 32'h1, "claim0");
    check_irq("svc0", 1'b0, 32'h1);
    bus_read(5'h04, 32'h0, "claim0_pending");
    bus_read(5'h08, 32'h0, "claim_in_svc");
    bus_write(5'h08, 32'h2, 4'hF);
    check_irq("bad_complete", 1'b0, 32'h1);
    bus_write(5'h08, 32'h1, 4'hF);
    tick();
    check_irq("done0", 1'b0, 32'h0);

    // Unmapped offsets and priority register
    bus_write(5'h14, 32'hFFFF_FFFF, 4'hF);
    bus_read(5'h14, 32'h0, "unmapped");
    bus_write(5'h0C, (32'h3 << 10) | (32'h1 << 4), 4'hF);
`ifdef INT_CTRL_PRIO_EN
    bus_read(5'h0C, (32'h3 << 10) | (32'h1 << 4), "prio_reg");
    first_id = 32'h6; second_id = 32'h3;
`else
    bus_read(5'h0C, 32'h0, "prio_reg");
    first_id = 32'h3; second_id = 32'h6;
`endif

    // Sources 2 and 5 rise together
    bus_write(5'h00, 32'hFF, 4'hF);
    src = 8'b0010_0100;
    tick();
    src = '0;
    tick();
    check_irq("pair_offer", 1'b1, first_id);
    bus_read(5'h08, first_id, "pair_claim1");
    bus_write(5'h08, first_id, 4'hF);
    check_irq("pair_idle", 1'b0, 32'h0);
    tick();
    check_irq("pair_offer2", 1'b1, second_id);
    bus_read(5'h08, second_id, "pair_claim2");
    bus_write(5'h08, second_id, 4'hF);
    tick();
    check_irq("pair_done", 1'b0, 32'h0);

    // Level held high yields a single pending
    src[0] = 1'b1;
    tick();
    tick();
    check_irq("hold_offer", 1'b1, 32'h1);
    bus_read(5'h08, 32'h1, "hold_claim");
    repeat (95) tick();
    bus_read(5'h04, 32'h0, "hold_pending");
    src[0] = 1'b0;
    tick();
    src[0] = 1'b1;
    tick();
    bus_read(5'h04, 32'h1, "svc_edge_pending");
    check_irq("svc_edge", 1'b0, 32'h1);
    bus_write(5'h08, 32'h1, 4'hF);
    check_irq("svc_edge_idle", 1'b0, 32'h0);
    tick();
    check_irq("svc_edge_offer", 1'b1, 32'h1);
    bus_read(5'h08, 32'h1, "svc_edge_claim");
    bus_write(5'h08, 32'h1, 4'hF);
    src[0] = 1'b0;
    tick();

    // Disabling while offering drops back to IDLE, pending kept
    src[1] = 1'b1;
    tick();
    src[1] = 1'b0;
    tick();
    check_irq("dis_offer", 1'b1, 32'h2);
    bus_write(5'h00, 32'h0, 4'hF);
    tick();
    check_irq("dis_idle", 1'b0, 32'h0);
    bus_read(5'h04, 32'h2, "dis_pending");
    bus_write(5'h00, 32'hFF, 4'b0010);
    bus_read(5'h00, 32'h0, "lane_skip");
    bus_write(5'h00, 32'h02, 4'b0001);
    tick();
    check_irq("lane_offer", 1'b1, 32'h2);
    bus_read(5'h08, 32'h2, "lane_claim");

    // Asynchronous reset in SERVICE
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", rdata, 32'h0);
    check_irq("arst", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(5'h04, 32'h0, "arst_pending");
    bus_read(5'h00, 32'h0, "arst_enable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
